dma_rd_mux: RTL and testbench

DMA_RD_MUX -- requirements
Module: dma_rd_mux

---
 rtl/dma_rd_mux_pkg.sv | 24 ++
 rtl/dma_rd_tag_fifo.sv | 61 ++++++
 rtl/dma_rd_mux.sv | 179 +++++++++++++++++
 tb/tb_dma_rd_mux.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_rd_mux_pkg.sv
// ------------------------------------------------------------------
// dma_rd_mux_pkg: shared constants and width helpers for dma_rd_mux
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dma_rd_mux_pkg;

  localparam int MAX_CH = 8;
  localparam int SRC_W  = 3;

  typedef logic [SRC_W-1:0] src_t;

  function automatic int req_pd_w(input int size_w, input int addr_w);
    return size_w + addr_w;
  endfunction

  function automatic int tag_w(input int size_w);
    return SRC_W + size_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_rd_tag_fifo.sv
// ------------------------------------------------------------------
// dma_rd_tag_fifo: show-ahead synchronous FIFO holding outstanding read tags
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dma_rd_tag_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == c_CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_cnt <= r_cnt + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dma_rd_mux.sv
// ------------------------------------------------------------------
// dma_rd_mux: round-robin DMA read request merge with in-order response routing
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dma_rd_mux
  import dma_rd_mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 64,
  parameter int SIZE_W   = 15,
  parameter int DATA_W   = 512,
  parameter int MAX_OUTS = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   cl_req_valid,
  output logic [NUM_CH-1:0]                   cl_req_ready,
  input  logic [NUM_CH*(SIZE_W+ADDR_W)-1:0]   cl_req_pd,
  output logic [NUM_CH-1:0]                   cl_rsp_valid,
  input  logic [NUM_CH-1:0]                   cl_rsp_ready,
  output logic [DATA_W-1:0]                   cl_rsp_pd,
  output logic                                rd_req_valid,
  input  logic                                rd_req_ready,
  output logic [SIZE_W+ADDR_W-1:0]            rd_req_pd,
  output logic [2:0]                          rd_req_src,
  input  logic                                rd_rsp_valid,
  output logic                                rd_rsp_ready,
  input  logic [DATA_W-1:0]                   rd_rsp_pd,
  output logic [$clog2(MAX_OUTS):0]           outs_cnt,
  output logic                                err
);

  localparam int c_PD_W  = req_pd_w(SIZE_W, ADDR_W);
  localparam int c_CNT_W = $clog2(MAX_OUTS) + 1;

  typedef struct packed {
    src_t              src;
    logic [SIZE_W-1:0] size;
  } tag_t;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("dma_rd_mux: NUM_CH out of range");
  end

  src_t              r_last;
  logic              r_skid_vld;
  logic [c_PD_W-1:0] r_skid_pd;
  src_t              r_skid_src;
  logic [SIZE_W-1:0] r_beat_cnt;
  logic              r_beat_act;
  logic              r_err;

  src_t              w_gnt_idx;
  logic              w_gnt_any;
  logic              w_gnt;
  logic              w_room;
  int                w_dist;
  int                w_best;
  tag_t              w_push_tag;
  tag_t              w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [c_CNT_W-1:0] w_fifo_cnt;
  logic [NUM_CH-1:0] w_head_sel;
  logic              w_head_rdy;
  logic              w_rsp_xfer;
  logic [SIZE_W-1:0] w_remain;

  // Pick the valid channel with the smallest rotated distance from last grant + 1
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_best    = NUM_CH;
    w_dist    = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_dist = (c + 2 * NUM_CH - int'(r_last) - 1) % NUM_CH;
      if (cl_req_valid[c] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_idx = src_t'(c);
        w_gnt_any = 1'b1;
      end
    end
  end

  // The skid entry counts against the outstanding budget before it reaches the FIFO
  assign w_room = (int'(w_fifo_cnt) + int'(r_skid_vld)) < MAX_OUTS;
  assign w_gnt  = w_gnt_any && (!r_skid_vld || rd_req_ready) && w_room && !reset;

  assign cl_req_ready = w_gnt ? (NUM_CH'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_vld <= 1'b0;
      r_skid_pd  <= '0;
      r_skid_src <= '0;
      r_last     <= src_t'(NUM_CH - 1);
    end else if (w_gnt) begin
      r_skid_vld <= 1'b1;
      r_skid_pd  <= cl_req_pd[int'(w_gnt_idx)*c_PD_W +: c_PD_W];
      r_skid_src <= w_gnt_idx;
      r_last     <= w_gnt_idx;
    end else if (rd_req_ready) begin
      r_skid_vld <= 1'b0;
    end
  end

  assign rd_req_valid = r_skid_vld && !reset;
  assign rd_req_pd    = r_skid_pd;
  assign rd_req_src   = reset ? 3'd0 : r_skid_src;

  assign w_push          = r_skid_vld && rd_req_ready;
  assign w_push_tag.src  = r_skid_src;
  assign w_push_tag.size = r_skid_pd[c_PD_W-1 -: SIZE_W];

  dma_rd_tag_fifo #(
    .WIDTH (tag_w(SIZE_W)),
    .DEPTH (MAX_OUTS)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_push_tag),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  always_comb begin
    w_head_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_head_sel[c] = (w_head.src == src_t'(c));
    end
  end

  assign w_head_rdy   = |(cl_rsp_ready & w_head_sel);
  assign cl_rsp_valid = (rd_rsp_valid && !w_empty && !reset) ? w_head_sel : '0;
  assign cl_rsp_pd    = rd_rsp_pd;
  assign rd_rsp_ready = !w_empty && w_head_rdy && !reset;

  // First beat of a burst takes its length straight from the head tag
  assign w_rsp_xfer = rd_rsp_valid && rd_rsp_ready;
  assign w_remain   = r_beat_act ? r_beat_cnt : w_head.size;
  assign w_pop      = w_rsp_xfer && (w_remain == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
      r_beat_act <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_rsp_xfer) begin
        if (w_remain == '0) begin
          r_beat_act <= 1'b0;
        end else begin
          r_beat_act <= 1'b1;
          r_beat_cnt <= w_remain - SIZE_W'(1);
        end
      end
      if (rd_rsp_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outs_cnt = reset ? '0 : w_fifo_cnt;
  assign err      = r_err;

  logic w_unused;
  assign w_unused = w_full;

endmodule

`default_nettype wire

// File: tb/tb_dma_rd_mux.sv
// ------------------------------------------------------------------
// tb_dma_rd_mux: directed table/sequence bench for dma_rd_mux
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dma_rd_mux;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int SW  = 4;
  localparam int DW  = 32;
  localparam int MO  = 4;
  localparam int PW  = SW + AW;

  logic                 clk;
  logic                 reset;
  logic [NCH-1:0]       cl_req_valid;
  logic [NCH-1:0]       cl_req_ready;
  logic [NCH*PW-1:0]    cl_req_pd;
  logic [NCH-1:0]       cl_rsp_valid;
  logic [NCH-1:0]       cl_rsp_ready;
  logic [DW-1:0]        cl_rsp_pd;
  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [PW-1:0]        rd_req_pd;
  logic [2:0]           rd_req_src;
  logic                 rd_rsp_valid;
  logic                 rd_rsp_ready;
  logic [DW-1:0]        rd_rsp_pd;
  logic [$clog2(MO):0]  outs_cnt;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;

  dma_rd_mux #(
    .NUM_CH   (NCH),
    .ADDR_W   (AW),
    .SIZE_W   (SW),
    .DATA_W   (DW),
    .MAX_OUTS (MO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cl_req_valid (cl_req_valid),
    .cl_req_ready (cl_req_ready),
    .cl_req_pd    (cl_req_pd),
    .cl_rsp_valid (cl_rsp_valid),
    .cl_rsp_ready (cl_rsp_ready),
    .cl_rsp_pd    (cl_rsp_pd),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_pd    (rd_req_pd),
    .rd_req_src   (rd_req_src),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_pd    (rd_rsp_pd),
    .outs_cnt     (outs_cnt),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NCH-1:0] valid;
    logic [NCH-1:0] exp_rdy;
  } arb_vec_t;

  arb_vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pd(input int ch, input logic [SW-1:0] sz, input logic [AW-1:0] ad);
    cl_req_pd[ch*PW +: PW] = {sz, ad};
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    cl_req_valid = '0;
    rd_rsp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input string nm);
    int k;
    k = 0;
    while (int'(outs_cnt) != target && k < 20) begin
      tick();
      k++;
    end
    chk(nm, 64'(outs_cnt), 64'(target));
  endtask

  function automatic int oh2idx(input logic [NCH-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NCH; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    int grants;
    int beat;
    int cyc;
    int exp_ch;
    logic stall;

    reset        = 1'b1;
    cl_req_valid = '0;
    cl_req_pd    = '0;
    cl_rsp_ready = '0;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_pd    = '0;

    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b1010, 4'b0010};
    vecs[6]  = '{4'b1010, 4'b1000};
    vecs[7]  = '{4'b1010, 4'b0010};
    vecs[8]  = '{4'b0001, 4'b0001};
    vecs[9]  = '{4'b0100, 4'b0100};
    vecs[10] = '{4'b0000, 4'b0000};
    vecs[11] = '{4'b0011, 4'b0001};

    // Reset state, with requests and responses being offered
    tick();
    cl_req_valid = 4'b1111;
    rd_rsp_valid = 1'b1;
    cl_rsp_ready = 4'b1111;
    rd_req_ready = 1'b1;
    #1;
    chk("rst_cl_req_ready", 64'(cl_req_ready), 64'd0);
    chk("rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_cl_rsp_valid", 64'(cl_rsp_valid), 64'd0);
    chk("rst_rd_rsp_ready", 64'(rd_rsp_ready), 64'd0);
    chk("rst_outs_cnt",     64'(outs_cnt),     64'd0);
    chk("rst_rd_req_src",   64'(rd_req_src),   64'd0);
    do_reset();

    // Round-robin table with an always-accepting single-beat responder
    for (int ch = 0; ch < NCH; ch++) set_pd(ch, 4'd0, 16'h0100 + 16'(ch));
    rd_req_ready = 1'b1;
    rd_rsp_valid = 1'b1;
    cl_rsp_ready = 4'b1111;
    rd_rsp_pd    = 32'hA5A5_0000;
    for (int i = 0; i < 12; i++) begin
      cl_req_valid = vecs[i].valid;
      #1;
      chk("arb_grant", 64'(cl_req_ready), 64'(vecs[i].exp_rdy));
      if (i > 0 && vecs[i-1].exp_rdy != '0) begin
        chk("arb_rd_req_valid", 64'(rd_req_valid), 64'd1);
        chk("arb_rd_req_src", 64'(rd_req_src), 64'(oh2idx(vecs[i-1].exp_rdy)));
        chk("arb_rd_req_pd", 64'(rd_req_pd), 64'({4'd0, 16'h0100 + 16'(oh2idx(vecs[i-1].exp_rdy))}));
      end else begin
        chk("arb_rd_req_idle", 64'(rd_req_valid), 64'd0);
      end
      tick();
    end
    cl_req_valid = '0;
    wait_cnt(0, "arb_drain");

    // Ch2 burst of 4 beats then ch0 single beat, with a 5-cycle ch2 stall
    do_reset();
    set_pd(2, 4'd3, 16'h0202);
    set_pd(0, 4'd0, 16'h0300);
    cl_rsp_ready = 4'b1111;
    cl_req_valid = 4'b0100;
    #1;
    chk("seq_gnt_ch2", 64'(cl_req_ready), 64'b0100);
    tick();
    cl_req_valid = 4'b0001;
    #1;
    chk("seq_gnt_ch0", 64'(cl_req_ready), 64'b0001);
    chk("seq_req_pd_ch2", 64'(rd_req_pd), 64'({4'd3, 16'h0202}));
    chk("seq_req_src_ch2", 64'(rd_req_src), 64'd2);
    tick();
    cl_req_valid = '0;
    wait_cnt(2, "seq_outs_2");
    beat = 0;
    cyc  = 0;
    rd_rsp_valid = 1'b1;
    while (beat < 5 && cyc < 30) begin
      stall        = (cyc >= 1 && cyc <= 5);
      exp_ch       = (beat < 4) ? 2 : 0;
      cl_rsp_ready = stall ? 4'b1011 : 4'b1111;
      rd_rsp_pd    = 32'hD000_0000 + 32'(beat);
      #1;
      chk("seq_rsp_valid", 64'(cl_rsp_valid), 64'(4'b0001 << exp_ch));
      chk("seq_rsp_ready", 64'(rd_rsp_ready), 64'(!(stall && exp_ch == 2)));
      chk("seq_rsp_pd", 64'(cl_rsp_pd), 64'(32'hD000_0000 + 32'(beat)));
      chk("seq_outs_cnt", 64'(outs_cnt), (beat < 4) ? 64'd2 : 64'd1);
      if (!(stall && exp_ch == 2)) beat++;
      tick();
      cyc++;
    end
    rd_rsp_valid = 1'b0;
    #1;
    chk("seq_beats_total", 64'(beat), 64'd5);
    chk("seq_outs_0", 64'(outs_cnt), 64'd0);
    chk("seq_rsp_idle", 64'(cl_rsp_valid), 64'd0);

    // Maximum size field: 16 beats on ch1
    do_reset();
    set_pd(1, 4'hF, 16'h1234);
    cl_req_valid = 4'b0010;
    #1;
    chk("max_gnt_ch1", 64'(cl_req_ready), 64'b0010);
    tick();
    cl_req_valid = '0;
    wait_cnt(1, "max_outs_1");
    beat = 0;
    cyc  = 0;
    rd_rsp_valid = 1'b1;
    cl_rsp_ready = 4'b1111;
    while (beat < 16 && cyc < 24) begin
      #1;
      chk("max_rsp_valid", 64'(cl_rsp_valid), 64'b0010);
      chk("max_outs_cnt", 64'(outs_cnt), 64'd1);
      beat++;
      tick();
      cyc++;
    end
    rd_rsp_valid = 1'b0;
    #1;
    chk("max_outs_0", 64'(outs_cnt), 64'd0);

    // Outstanding limit of 4 with responses withheld
    do_reset();
    for (int ch = 0; ch < NCH; ch++) set_pd(ch, 4'd0, 16'h0400 + 16'(ch));
    rd_req_ready = 1'b1;
    cl_req_valid = 4'b1111;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      grants += $countones(cl_req_ready & cl_req_valid);
      tick();
    end
    #1;
    chk("lim_grants", 64'(grants), 64'd4);
    chk("lim_outs_4", 64'(outs_cnt), 64'd4);
    chk("lim_no_grant", 64'(cl_req_ready), 64'd0);
    rd_rsp_valid = 1'b1;
    #1;
    chk("lim_rsp_head_ch0", 64'(cl_rsp_valid), 64'b0001);
    tick();
    rd_rsp_valid = 1'b0;
    #1;
    chk("lim_outs_3", 64'(outs_cnt), 64'd3);
    chk("lim_resume_gnt", 64'(cl_req_ready), 64'b0001);
    tick();
    #1;
    chk("lim_blocked_again", 64'(cl_req_ready), 64'd0);
    chk("lim_fifth_src", 64'(rd_req_src), 64'd0);
    cl_req_valid = '0;
    tick();
    chk("lim_outs_4b", 64'(outs_cnt), 64'd4);
    rd_rsp_valid = 1'b1;
    tick();
    rd_rsp_valid = 1'b0;
    #1;
    chk("lim_outs_3b", 64'(outs_cnt), 64'd3);

    // Reset with 3 outstanding while traffic is offered
    cl_req_valid = 4'b1111;
    rd_rsp_valid = 1'b1;
    reset        = 1'b1;
    #1;
    chk("mid_rst_outs", 64'(outs_cnt), 64'd0);
    chk("mid_rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
    chk("mid_rst_rsp_ready", 64'(rd_rsp_ready), 64'd0);
    chk("mid_rst_cl_rsp_valid", 64'(cl_rsp_valid), 64'd0);
    tick();
    reset        = 1'b0;
    rd_rsp_valid = 1'b0;
    #1;
    chk("post_rst_outs", 64'(outs_cnt), 64'd0);
    chk("post_rst_gnt_ch0", 64'(cl_req_ready), 64'b0001);
    chk("post_rst_err", 64'(err), 64'd0);

    // Response with nothing outstanding
    do_reset();
    rd_rsp_valid = 1'b1;
    cl_rsp_ready = 4'b1111;
    #1;
    chk("err_rsp_ready", 64'(rd_rsp_ready), 64'd0);
    chk("err_cl_rsp_valid", 64'(cl_rsp_valid), 64'd0);
    chk("err_before", 64'(err), 64'd0);
    tick();
    rd_rsp_valid = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    tick();
    chk("err_sticky", 64'(err), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
